// File: rtl/wb_trace_pkg.sv
// Shared types for the writeback trace checker: FSM states and the
// expected-list entry layout used by the 16-bit CPU/AES core.
package wb_trace_pkg;

    localparam int CORE_DATA_W = 16;
    localparam int CORE_REG_AW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // chk_rd = 0 lets an entry match a write to any destination register
    typedef struct packed {
        logic                   chk_rd;
        logic [CORE_REG_AW-1:0] rd;
        logic [CORE_DATA_W-1:0] val;
    } exp_entry_t;

    function automatic exp_entry_t make_entry(input logic                   chk,
                                              input logic [CORE_REG_AW-1:0] rd,
                                              input logic [CORE_DATA_W-1:0] val);
        exp_entry_t e;
        e.chk_rd = chk;
        e.rd     = rd;
        e.val    = val;
        return e;
    endfunction

endpackage

// File: rtl/wb_trace_exp_mem.sv
// Expected-write list: register array with one write port and a
// combinational read port so the current entry is visible the same cycle.
module wb_trace_exp_mem #(
    parameter int DEPTH   = 64,
    parameter int AW      = 6,
    parameter int ENTRY_W = 21
) (
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [AW-1:0]      waddr_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    input  logic [AW-1:0]      raddr_i,
    output logic [ENTRY_W-1:0] rdata_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    // Contents are deliberately not reset so a list loaded once survives reruns
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/wb_trace_checker.sv
// Writeback trace checker: compares each retired register write against a
// preloaded expected list, reporting pass/fail, first failing entry and
// a watchdog timeout between successive matches.
module wb_trace_checker
    import wb_trace_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int REG_AW  = 4,
    parameter int PC_W    = 16,
    parameter int DEPTH   = 64,
    parameter int TIMEOUT = 256
) (
    input  logic                       clk_i,
    input  logic                       reset,
    input  logic                       exp_we_i,
    input  logic [$clog2(DEPTH)-1:0]   exp_addr_i,
    input  logic [REG_AW+DATA_W:0]     exp_data_i,
    input  logic [$clog2(DEPTH):0]     num_exp_i,
    input  logic                       mode_i,
    input  logic                       start_i,
    input  logic                       wb_valid_i,
    input  logic [REG_AW-1:0]          wb_rd_i,
    input  logic [DATA_W-1:0]          wb_val_i,
    input  logic [PC_W-1:0]            pc_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       pass_o,
    output logic                       timeout_o,
    output logic [$clog2(DEPTH):0]     fail_idx_o,
    output logic [DATA_W-1:0]          fail_val_o,
    output logic [PC_W-1:0]            fail_pc_o,
    output logic [$clog2(DEPTH):0]     match_cnt_o,
    output logic [15:0]                skip_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = 1 + REG_AW + DATA_W;
    localparam int TW = $clog2(TIMEOUT) + 1;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     num_exp_q, num_exp_d;
    logic              mode_q, mode_d;
    logic [15:0]       skip_q, skip_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              pass_q, pass_d;
    logic              timeout_q, timeout_d;
    logic [PW-1:0]     fail_idx_q, fail_idx_d;
    logic [DATA_W-1:0] fail_val_q, fail_val_d;
    logic [PC_W-1:0]   fail_pc_q, fail_pc_d;

    logic [EW-1:0]     entry;
    logic              entry_chk;
    logic [REG_AW-1:0] entry_rd;
    logic [DATA_W-1:0] entry_val;
    logic              wb_hit;

    // List writes are locked out while a run is consuming the list
    wb_trace_exp_mem #(
        .DEPTH   (DEPTH),
        .AW      (AW),
        .ENTRY_W (EW)
    ) u_exp_mem (
        .clk_i   (clk_i),
        .we_i    (exp_we_i && (state_q != RUN)),
        .waddr_i (exp_addr_i),
        .wdata_i (exp_data_i),
        .raddr_i (ptr_q[AW-1:0]),
        .rdata_o (entry)
    );

    assign entry_chk = entry[EW-1];
    assign entry_rd  = entry[EW-2:DATA_W];
    assign entry_val = entry[DATA_W-1:0];

    // Decode whether this cycle's writeback satisfies the current entry
    always_comb begin
        wb_hit = wb_valid_i && (wb_val_i == entry_val) &&
                 (!entry_chk || (wb_rd_i == entry_rd));
    end

    // Next-state and result logic; a match always beats a watchdog expiry
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        num_exp_d  = num_exp_q;
        mode_d     = mode_q;
        skip_d     = skip_q;
        timer_d    = timer_q;
        pass_d     = pass_q;
        timeout_d  = timeout_q;
        fail_idx_d = fail_idx_q;
        fail_val_d = fail_val_q;
        fail_pc_d  = fail_pc_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d    = RUN;
                    ptr_d      = '0;
                    num_exp_d  = num_exp_i;
                    mode_d     = mode_i;
                    skip_d     = '0;
                    timer_d    = '0;
                    pass_d     = 1'b0;
                    timeout_d  = 1'b0;
                    fail_idx_d = '0;
                    fail_val_d = '0;
                    fail_pc_d  = '0;
                end
            end
            RUN: begin
                if (num_exp_q == '0) begin
                    state_d = DONE;
                    pass_d  = 1'b1;
                end else if (wb_hit) begin
                    ptr_d   = ptr_q + 1'b1;
                    timer_d = '0;
                    if (ptr_d == num_exp_q) begin
                        state_d = DONE;
                        pass_d  = 1'b1;
                    end
                end else if (wb_valid_i && !mode_q) begin
                    state_d    = DONE;
                    fail_idx_d = ptr_q;
                    fail_val_d = wb_val_i;
                    fail_pc_d  = pc_i;
                end else begin
                    if (wb_valid_i && (skip_q != 16'hFFFF)) begin
                        skip_d = skip_q + 16'd1;
                    end
                    if (timer_q == TW'(TIMEOUT - 1)) begin
                        state_d    = DONE;
                        timeout_d  = 1'b1;
                        fail_idx_d = ptr_q;
                        fail_val_d = '0;
                        fail_pc_d  = pc_i;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and status registers; reset drops straight back to IDLE
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            num_exp_q  <= '0;
            mode_q     <= 1'b0;
            skip_q     <= '0;
            timer_q    <= '0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
            fail_idx_q <= '0;
            fail_val_q <= '0;
            fail_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            num_exp_q  <= num_exp_d;
            mode_q     <= mode_d;
            skip_q     <= skip_d;
            timer_q    <= timer_d;
            pass_q     <= pass_d;
            timeout_q  <= timeout_d;
            fail_idx_q <= fail_idx_d;
            fail_val_q <= fail_val_d;
            fail_pc_q  <= fail_pc_d;
        end
    end

    assign busy_o      = (state_q == RUN);
    assign done_o      = (state_q == DONE);
    assign pass_o      = pass_q;
    assign timeout_o   = timeout_q;
    assign fail_idx_o  = fail_idx_q;
    assign fail_val_o  = fail_val_q;
    assign fail_pc_o   = fail_pc_q;
    assign match_cnt_o = ptr_q;
    assign skip_cnt_o  = skip_q;

endmodule

// File: tb/tb_wb_trace_checker.sv
// Directed bench for wb_trace_checker: a vector table for the basic strict
// run plus hand-written sequences for failure, skip, watchdog and reset.
module tb_wb_trace_checker;
    import wb_trace_pkg::*;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;

    logic        clk_i = 1'b0;
    logic        reset;
    logic        exp_we_i;
    logic [2:0]  exp_addr_i;
    logic [20:0] exp_data_i;
    logic [3:0]  num_exp_i;
    logic        mode_i;
    logic        start_i;
    logic        wb_valid_i;
    logic [3:0]  wb_rd_i;
    logic [15:0] wb_val_i;
    logic [15:0] pc_i;
    logic        busy_o, done_o, pass_o, timeout_o;
    logic [3:0]  fail_idx_o, match_cnt_o;
    logic [15:0] fail_val_o, fail_pc_o, skip_cnt_o;

    int compared_cnt = 0;
    int mismatch_cnt = 0;

    typedef struct {
        logic        valid;
        logic [3:0]  rd;
        logic [15:0] val;
        logic [15:0] pc;
        logic        exp_busy;
        logic        exp_done;
        logic        exp_pass;
        logic [3:0]  exp_match;
        logic [15:0] exp_skip;
    } vec_t;

    vec_t vecs[5];

    wb_trace_checker #(
        .DATA_W (16), .REG_AW (4), .PC_W (16),
        .DEPTH (DEPTH), .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i (clk_i), .reset (reset),
        .exp_we_i (exp_we_i), .exp_addr_i (exp_addr_i), .exp_data_i (exp_data_i),
        .num_exp_i (num_exp_i), .mode_i (mode_i), .start_i (start_i),
        .wb_valid_i (wb_valid_i), .wb_rd_i (wb_rd_i), .wb_val_i (wb_val_i), .pc_i (pc_i),
        .busy_o (busy_o), .done_o (done_o), .pass_o (pass_o), .timeout_o (timeout_o),
        .fail_idx_o (fail_idx_o), .fail_val_o (fail_val_o), .fail_pc_o (fail_pc_o),
        .match_cnt_o (match_cnt_o), .skip_cnt_o (skip_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        compared_cnt++;
        if (act !== expv) begin
            mismatch_cnt++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Drive one writeback (or idle cycle) and clock it in
    task automatic applyStimulus(input logic v, input logic [3:0] rd,
                                 input logic [15:0] val, input logic [15:0] pc);
        wb_valid_i = v;
        wb_rd_i    = rd;
        wb_val_i   = val;
        pc_i       = pc;
        step();
        wb_valid_i = 1'b0;
    endtask

    task automatic writeEntry(input logic [2:0] addr, input exp_entry_t e);
        exp_we_i   = 1'b1;
        exp_addr_i = addr;
        exp_data_i = e;
        step();
        exp_we_i   = 1'b0;
    endtask

    task automatic startRun(input logic [3:0] n, input logic m);
        start_i   = 1'b1;
        num_exp_i = n;
        mode_i    = m;
        step();
        start_i   = 1'b0;
    endtask

    task automatic loadBasicList();
        writeEntry(3'd0, make_entry(1'b0, 4'd0, 16'd3));
        writeEntry(3'd1, make_entry(1'b0, 4'd0, 16'd1));
        writeEntry(3'd2, make_entry(1'b0, 4'd0, 16'd2));
    endtask

    initial begin
        int cycles;
        vecs[0] = '{1'b1, 4'd5, 16'd3,  16'h0100, 1'b1, 1'b0, 1'b0, 4'd1, 16'd0};
        vecs[1] = '{1'b0, 4'd0, 16'd0,  16'h0101, 1'b1, 1'b0, 1'b0, 4'd1, 16'd0};
        vecs[2] = '{1'b1, 4'd9, 16'd1,  16'h0102, 1'b1, 1'b0, 1'b0, 4'd2, 16'd0};
        vecs[3] = '{1'b1, 4'd1, 16'd2,  16'h0104, 1'b0, 1'b1, 1'b1, 4'd3, 16'd0};
        vecs[4] = '{1'b1, 4'd1, 16'd99, 16'h0106, 1'b0, 1'b1, 1'b1, 4'd3, 16'd0};

        reset = 1'b1; exp_we_i = 1'b0; exp_addr_i = '0; exp_data_i = '0;
        num_exp_i = '0; mode_i = 1'b0; start_i = 1'b0;
        wb_valid_i = 1'b0; wb_rd_i = '0; wb_val_i = '0; pc_i = '0;
        step(); step();
        reset = 1'b0;
        step();
        checkOutput("reset busy", busy_o, 0);
        checkOutput("reset done", done_o, 0);
        checkOutput("reset pass", pass_o, 0);
        checkOutput("reset match", match_cnt_o, 0);

        // Strict pass via vector table
        loadBasicList();
        startRun(4'd3, 1'b0);
        checkOutput("start busy", busy_o, 1);
        checkOutput("start match", match_cnt_o, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].rd, vecs[i].val, vecs[i].pc);
            checkOutput($sformatf("vec%0d busy", i),  busy_o,      vecs[i].exp_busy);
            checkOutput($sformatf("vec%0d done", i),  done_o,      vecs[i].exp_done);
            checkOutput($sformatf("vec%0d pass", i),  pass_o,      vecs[i].exp_pass);
            checkOutput($sformatf("vec%0d match", i), match_cnt_o, vecs[i].exp_match);
            checkOutput($sformatf("vec%0d skip", i),  skip_cnt_o,  vecs[i].exp_skip);
        end

        // Strict mismatch on second entry
        startRun(4'd3, 1'b0);
        checkOutput("rerun done cleared", done_o, 0);
        checkOutput("rerun pass cleared", pass_o, 0);
        applyStimulus(1'b1, 4'd3, 16'd3, 16'h0200);
        checkOutput("strict m1 match", match_cnt_o, 1);
        applyStimulus(1'b1, 4'd4, 16'd5, 16'h0202);
        checkOutput("strict fail done", done_o, 1);
        checkOutput("strict fail busy", busy_o, 0);
        checkOutput("strict fail pass", pass_o, 0);
        checkOutput("strict fail idx", fail_idx_o, 1);
        checkOutput("strict fail val", fail_val_o, 5);
        checkOutput("strict fail pc", fail_pc_o, 16'h0202);
        checkOutput("strict fail timeout", timeout_o, 0);

        // Skip mode with Rd checking
        writeEntry(3'd0, make_entry(1'b1, 4'd2, 16'h3925));
        writeEntry(3'd1, make_entry(1'b1, 4'd2, 16'h841D));
        startRun(4'd2, 1'b1);
        applyStimulus(1'b1, 4'd2, 16'h3925, 16'h0300);
        checkOutput("skip m1 match", match_cnt_o, 1);
        applyStimulus(1'b1, 4'd3, 16'h841D, 16'h0302);
        checkOutput("skip ignored busy", busy_o, 1);
        checkOutput("skip ignored cnt", skip_cnt_o, 1);
        checkOutput("skip ignored match", match_cnt_o, 1);
        applyStimulus(1'b1, 4'd2, 16'h841D, 16'h0304);
        checkOutput("skip done", done_o, 1);
        checkOutput("skip pass", pass_o, 1);
        checkOutput("skip match", match_cnt_o, 2);
        checkOutput("skip cnt final", skip_cnt_o, 1);

        // Watchdog: no writes, expect expiry 16 cycles after busy rises
        writeEntry(3'd0, make_entry(1'b0, 4'd0, 16'd4));
        pc_i = 16'h0BAD;
        startRun(4'd1, 1'b0);
        checkOutput("wd busy", busy_o, 1);
        cycles = 0;
        while (!done_o && cycles < 40) begin
            step();
            cycles++;
        end
        checkOutput("wd cycles", cycles, TIMEOUT);
        checkOutput("wd timeout", timeout_o, 1);
        checkOutput("wd pass", pass_o, 0);
        checkOutput("wd idx", fail_idx_o, 0);
        checkOutput("wd val", fail_val_o, 0);
        checkOutput("wd pc", fail_pc_o, 16'h0BAD);
        checkOutput("wd busy low", busy_o, 0);

        // Empty list passes one cycle after start
        startRun(4'd0, 1'b0);
        checkOutput("empty busy", busy_o, 1);
        checkOutput("empty done early", done_o, 0);
        step();
        checkOutput("empty done", done_o, 1);
        checkOutput("empty pass", pass_o, 1);
        checkOutput("empty timeout", timeout_o, 0);

        // Reset mid-run clears everything and parks in IDLE
        startRun(4'd2, 1'b0);
        applyStimulus(1'b1, 4'd0, 16'd4, 16'h0400);
        checkOutput("pre-reset match", match_cnt_o, 1);
        reset = 1'b1;
        #2;
        checkOutput("mid reset busy", busy_o, 0);
        checkOutput("mid reset done", done_o, 0);
        checkOutput("mid reset match", match_cnt_o, 0);
        checkOutput("mid reset pass", pass_o, 0);
        step();
        reset = 1'b0;
        applyStimulus(1'b1, 4'd0, 16'd4, 16'h0402);
        checkOutput("idle wb busy", busy_o, 0);
        checkOutput("idle wb match", match_cnt_o, 0);

        // Write and start in the same cycle: run sees the new entry
        exp_we_i = 1'b1; exp_addr_i = 3'd0; exp_data_i = make_entry(1'b0, 4'd0, 16'd7);
        start_i = 1'b1; num_exp_i = 4'd1; mode_i = 1'b0;
        step();
        exp_we_i = 1'b0; start_i = 1'b0;
        applyStimulus(1'b1, 4'd1, 16'd7, 16'h0500);
        checkOutput("we+start done", done_o, 1);
        checkOutput("we+start pass", pass_o, 1);

        // List write during a run is ignored
        loadBasicList();
        startRun(4'd3, 1'b0);
        exp_we_i = 1'b1; exp_addr_i = 3'd0; exp_data_i = make_entry(1'b0, 4'd0, 16'h0055);
        step();
        exp_we_i = 1'b0;
        applyStimulus(1'b1, 4'd1, 16'd3, 16'h0600);
        applyStimulus(1'b1, 4'd2, 16'd1, 16'h0602);
        applyStimulus(1'b1, 4'd3, 16'd2, 16'h0604);
        checkOutput("busy-we done", done_o, 1);
        checkOutput("busy-we pass", pass_o, 1);
        checkOutput("busy-we match", match_cnt_o, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_cnt, mismatch_cnt);
        $finish;
    end

endmodule

// File: doc/wb_trace_checker.md
# wb_trace_checker

Synthesizable writeback trace checker for the pipelined 16-bit CPU/AES core. It snoops the register-file writeback port (Rd index, Rd value, PC) and compares each retired write against a preloaded list of expected writes. It reports pass/fail, the first failing entry, and a watchdog timeout, so the on-chip smoke programme (ALU, branch, load/store, AES encrypt/decrypt) self-checks in silicon without an external bench. It is parametrised in data width, register-address width, list depth and match mode.

## Interface
- DATA_W, 16, width of writeback value
- REG_AW, 4, width of register index
- PC_W, 16, width of PC
- DEPTH, 64, expected-list entries (power of two)
- TIMEOUT, 256, max cycles between successive matches
- clk_i  in  1  clock
- reset  in  1  asynchronous, active-high reset
- exp_we_i  in  1  expected-list write strobe (honoured only in IDLE/DONE)
- exp_addr_i  in  $clog2(DEPTH)  expected-list write address
- exp_data_i  in  1+REG_AW+DATA_W  entry {chk_rd, rd, val}; chk_rd=0 means any Rd
- num_exp_i  in  $clog2(DEPTH)+1  number of entries to check (sampled at start)
- mode_i  in  1  0 = strict (every write must match in order), 1 = skip (non-matching writes ignored); sampled at start
- start_i  in  1  begin a run (honoured in IDLE/DONE)
- wb_valid_i  in  1  writeback occurs this cycle
- wb_rd_i  in  REG_AW  writeback register index
- wb_val_i  in  DATA_W  writeback value
- pc_i  in  PC_W  PC associated with writeback
- busy_o  out  1  run in progress
- done_o  out  1  run finished (level, held until next start)
- pass_o  out  1  valid when done_o; 1 = all entries matched
- timeout_o  out  1  valid when done_o; failure caused by watchdog
- fail_idx_o  out  $clog2(DEPTH)+1  entry index at failure
- fail_val_o  out  DATA_W  offending wb value (0 on timeout)
- fail_pc_o  out  PC_W  PC of offending write (PC at expiry on timeout)
- match_cnt_o  out  $clog2(DEPTH)+1  entries matched so far
- skip_cnt_o  out  16  writes ignored in skip mode (saturating)

## Operation
- States: IDLE -> RUN on start_i; RUN -> DONE on pass, mismatch (strict), or timeout; DONE -> RUN on start_i. No path back to IDLE except reset.
- start_i: ptr, match_cnt, skip_cnt, timer cleared; num_exp and mode latched; fail_* cleared.
- Match rule: wb_valid_i && wb_val_i==entry.val && (!entry.chk_rd || wb_rd_i==entry.rd).
- Match: ptr++, match_cnt++, timer cleared. When ptr reaches num_exp: DONE, pass_o=1.
- Non-match, strict: DONE, pass_o=0, fail_idx_o=ptr, fail_val_o/fail_pc_o captured from that write.
- Non-match, skip: skip_cnt++ (saturate at 16'hFFFF), no state change.
- Timer increments every RUN cycle without a match; reaching TIMEOUT-1 with no match in that cycle: DONE, pass_o=0, timeout_o=1, fail_idx_o=ptr.
- Same-cycle match and timer expiry: match wins.
- num_exp_i=0 at start: DONE with pass_o=1 one cycle after start.
- exp_we_i and start_i both asserted in the same cycle: write lands first; start reads post-write contents on the next cycle.
- exp_we_i while busy_o: ignored. start_i while busy_o: ignored.
- wb_valid_i outside RUN: ignored.

## Timing
- Reset: state IDLE; every output 0. Expected-list contents are not reset.
- Writeback sampled at posedge; status outputs update the same edge (1-cycle latency from wb to done_o/pass_o/match_cnt_o).
- busy_o high from the cycle after start_i until the cycle done_o rises; never both high.
- Reset mid-run: immediate return to IDLE; a new start_i is required.
- Expected-list read is combinational from ptr (register array); a write takes effect at the next edge.

## Structure
- Package wb_trace_pkg: state enum (IDLE, RUN, DONE), packed struct exp_entry_t {chk_rd, rd, val} parametrised via localparams matching the core's 16-bit/4-bit defaults.
- Sub-module wb_trace_exp_mem: DEPTH x entry register array, one write port, one async read port.

## Test plan
- Strict, list {3,1,2} with chk_rd=0; drive writes 3,1,2 -> done_o after 3rd write, pass_o=1, match_cnt_o=3.
- Strict, list {3,1,2}; drive 3,5 -> done_o, pass_o=0, fail_idx_o=1, fail_val_o=5, fail_pc_o = PC of the write of 5.
- Skip, list {16'h3925,16'h841D} with chk_rd=1, rd=2; drive (r2,0x3925),(r3,0x841D),(r2,0x841D) -> pass_o=1, skip_cnt_o=1.
- TIMEOUT=16, list {4}; start, no writes -> done_o and timeout_o exactly 16 cycles after busy_o rises, fail_idx_o=0.
- num_exp_i=0 -> pass_o=1 one cycle after start; then reset asserted mid-run of a 2nd start -> all outputs 0, state IDLE.
- exp_we_i during RUN to entry 0 -> list unchanged; run result identical to baseline.
